// File: rtl/multi_channel_interval_timer.sv
// multi_channel_interval_timer: NUM_CH prescaled down-counting interval timers behind one 32-bit Avalon-MM slave.
// Each channel has one-shot/continuous mode, a snapshot register and its own interrupt.
// Defining TIMER_PWM_EN adds a per-channel COMPARE register (reg 4) and registered pwm_out drive.
module multi_channel_interval_timer #(
   parameter int NUM_CH     = 2,
   parameter int CNT_W      = 32,
   parameter int PERIOD_RST = 49999
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [$clog2(NUM_CH)+2:0] address,
   input  logic                      chipselect,
   input  logic                      write_n,
   input  logic [31:0]               writedata,
   output logic [31:0]               readdata,
   output logic [NUM_CH-1:0]         irq,
   output logic                      irq_any,
   output logic [NUM_CH-1:0]         pwm_out
);
   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(PERIOD_RST);
   logic [31:0]       ch_sel;
   logic [2:0]        reg_sel;
   logic              wr;
   logic [NUM_CH-1:0] wr_st, wr_ct, wr_pe, wr_sn, start, stop, tick, tov;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [CNT_W-1:0]  per_q [NUM_CH];
   logic [CNT_W-1:0]  per_d [NUM_CH];
   logic [CNT_W-1:0]  snap_q [NUM_CH];
   logic [CNT_W-1:0]  snap_d [NUM_CH];
   logic [7:0]        pre_q [NUM_CH];
   logic [7:0]        pre_d [NUM_CH];
   logic [7:0]        pcnt_q [NUM_CH];
   logic [7:0]        pcnt_d [NUM_CH];
   logic [NUM_CH-1:0] ito_q, ito_d, cont_q, cont_d, to_q, to_d, run_q, run_d;
   logic [31:0]       rd_q, rd_d;
`ifdef TIMER_PWM_EN
   logic [CNT_W-1:0]  cmp_q [NUM_CH];
   logic [CNT_W-1:0]  cmp_d [NUM_CH];
   logic [NUM_CH-1:0] wr_cm, pwm_q, pwm_d;
`endif

   assign wr      = chipselect && !write_n;
   assign ch_sel  = 32'(address >> 3);
   assign reg_sel = address[2:0];
   assign irq     = to_q & ito_q;
   assign irq_any = |irq;
   assign readdata = rd_q;

   // Split a bus write into per-channel register strobes; derive prescaler ticks and timeouts.
   always_comb begin
      wr_st = '0;
      wr_ct = '0;
      wr_pe = '0;
      wr_sn = '0;
      start = '0;
      stop  = '0;
      tick  = '0;
      tov   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_st[i] = wr && ch_sel == i && reg_sel == 3'd0;
         wr_ct[i] = wr && ch_sel == i && reg_sel == 3'd1;
         wr_pe[i] = wr && ch_sel == i && reg_sel == 3'd2;
         wr_sn[i] = wr && ch_sel == i && reg_sel == 3'd3;
         start[i] = wr_ct[i] && writedata[2];
         stop[i]  = wr_ct[i] && writedata[3];
         tick[i]  = run_q[i] && pcnt_q[i] == pre_q[i];
         tov[i]   = tick[i] && cnt_q[i] == '0;
      end
   end

   // Channel next state: a PERIOD write reloads and stops, START beats STOP, a timeout set beats a STATUS clear.
   always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      snap_d = snap_q;
      pre_d  = pre_q;
      pcnt_d = pcnt_q;
      ito_d  = ito_q;
      cont_d = cont_q;
      to_d   = to_q;
      run_d  = run_q;
      for (int i = 0; i < NUM_CH; i++) begin
         pcnt_d[i] = (start[i] || wr_pe[i] || tick[i]) ? 8'd0 : run_q[i] ? pcnt_q[i] + 8'd1 : pcnt_q[i];
         cnt_d[i]  = wr_pe[i] ? writedata[CNT_W-1:0] : !tick[i] ? cnt_q[i] : tov[i] ? per_q[i] : cnt_q[i] - CNT_W'(1);
         per_d[i]  = wr_pe[i] ? writedata[CNT_W-1:0] : per_q[i];
         snap_d[i] = wr_sn[i] ? cnt_q[i] : snap_q[i];
         pre_d[i]  = wr_ct[i] ? writedata[15:8] : pre_q[i];
         ito_d[i]  = wr_ct[i] ? writedata[0] : ito_q[i];
         cont_d[i] = wr_ct[i] ? writedata[1] : cont_q[i];
         to_d[i]   = tov[i] || (to_q[i] && !wr_st[i]);
         run_d[i]  = wr_pe[i] ? 1'b0 : start[i] ? 1'b1 : stop[i] ? 1'b0 : (tov[i] && !cont_q[i]) ? 1'b0 : run_q[i];
      end
   end

   // Read mux follows the address every cycle; unmapped channels and reserved registers read 0.
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == i)
            rd_d = reg_sel == 3'd0 ? {30'd0, run_q[i], to_q[i]} :
                   reg_sel == 3'd1 ? {16'd0, pre_q[i], 6'd0, cont_q[i], ito_q[i]} :
                   reg_sel == 3'd2 ? 32'(per_q[i]) :
                   reg_sel == 3'd3 ? 32'(snap_q[i]) :
`ifdef TIMER_PWM_EN
                   reg_sel == 3'd4 ? 32'(cmp_q[i]) :
`endif
                   32'd0;
      end
   end

   // Channel and read-data registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]  <= CNT_RST;
            per_q[i]  <= CNT_RST;
            snap_q[i] <= '0;
            pre_q[i]  <= '0;
            pcnt_q[i] <= '0;
         end
         ito_q  <= '0;
         cont_q <= '0;
         to_q   <= '0;
         run_q  <= '0;
         rd_q   <= '0;
      end else begin
         cnt_q  <= cnt_d;
         per_q  <= per_d;
         snap_q <= snap_d;
         pre_q  <= pre_d;
         pcnt_q <= pcnt_d;
         ito_q  <= ito_d;
         cont_q <= cont_d;
         to_q   <= to_d;
         run_q  <= run_d;
         rd_q   <= rd_d;
      end
   end

`ifdef TIMER_PWM_EN
   // COMPARE writes and PWM level, which trails the counter and RUN by one cycle.
   always_comb begin
      wr_cm = '0;
      cmp_d = cmp_q;
      pwm_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_cm[i] = wr && ch_sel == i && reg_sel == 3'd4;
         cmp_d[i] = wr_cm[i] ? writedata[CNT_W-1:0] : cmp_q[i];
         pwm_d[i] = run_q[i] && cnt_q[i] <= cmp_q[i];
      end
   end

   // COMPARE and PWM output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) cmp_q[i] <= '0;
         pwm_q <= '0;
      end else begin
         cmp_q <= cmp_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;
`else
   assign pwm_out = '0;
`endif
endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// tb_multi_channel_interval_timer: scoreboard bench; stimulus queues expected values, a monitor pops and compares.
module tb_multi_channel_interval_timer;
   typedef struct {
      string       name;
      logic [31:0] exp;
      logic [31:0] mask;
   } item_t;
`ifdef TIMER_PWM_EN
   localparam bit PWM_ON = 1'b1;
`else
   localparam bit PWM_ON = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [4:0]  address = '0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [2:0]  irq, pwm_out;
   logic        irq_any;
   logic        rd_req = 1'b0, rd_vld = 1'b0, probe = 1'b0, end_chk = 1'b0;
   logic [19:0] pwm_pat = 20'b1110_0000_0111_1000_0000;
   int          checks = 0, failures = 0;
   item_t       rdq[$], pq[$];
   item_t       mon_it;
   wire  [31:0] obs = {25'd0, pwm_out, irq_any, irq};

   always #5 clk = ~clk;

   multi_channel_interval_timer #(.NUM_CH(3), .CNT_W(16), .PERIOD_RST(49999)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(readdata), .irq(irq), .irq_any(irq_any), .pwm_out(pwm_out)
   );

   function automatic logic [4:0] adr(int ch, int r);
      return 5'(ch * 8 + r);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) step();
   endtask

   task automatic wr(logic [4:0] a, logic [31:0] d);
      address = a;
      writedata = d;
      chipselect = 1'b1;
      write_n = 1'b0;
      step();
      chipselect = 1'b0;
      write_n = 1'b1;
   endtask

   task automatic rd(string n, logic [4:0] a, logic [31:0] e);
      item_t it;
      it.name = n;
      it.exp = e;
      it.mask = '1;
      rdq.push_back(it);
      address = a;
      chipselect = 1'b1;
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      chipselect = 1'b0;
   endtask

   task automatic chk(string n, logic [31:0] e, logic [31:0] m);
      item_t it;
      it.name = n;
      it.exp = e;
      it.mask = m;
      pq.push_back(it);
      probe = 1'b1;
      step();
      probe = 1'b0;
   endtask

   // Read data is due one cycle after the address was presented.
   always @(posedge clk) rd_vld <= rd_req;

   // Monitor: pop the scoreboard whenever a read result or a probe window is presented.
   always @(negedge clk) begin
      if (rd_vld) begin
         checks++;
         if (rdq.size() == 0) begin
            failures++;
            $display("FAIL rd_underflow readdata=%h required=<none queued>", readdata);
         end else begin
            mon_it = rdq.pop_front();
            if (readdata !== mon_it.exp) begin
               failures++;
               $display("FAIL %s readdata=%h required=%h", mon_it.name, readdata, mon_it.exp);
            end
         end
      end
      if (probe) begin
         checks++;
         if (pq.size() == 0) begin
            failures++;
            $display("FAIL probe_underflow obs=%h required=<none queued>", obs);
         end else begin
            mon_it = pq.pop_front();
            if ((obs & mon_it.mask) !== mon_it.exp) begin
               failures++;
               $display("FAIL %s obs=%h required=%h", mon_it.name, obs & mon_it.mask, mon_it.exp);
            end
         end
      end
      if (end_chk) begin
         checks++;
         if (rdq.size() + pq.size() != 0) begin
            failures++;
            $display("FAIL leftover pending=%0d required=0", rdq.size() + pq.size());
         end
      end
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL watchdog time=%0t required=finish", $time);
      $fatal(1, "watchdog");
   end

   // Directed stimulus; every expected value is worked out by hand from the timing rules.
   initial begin
      idle(3);
      reset = 1'b0;
      chk("rst_outputs", 32'h0, 32'h7F);
      rd("rst_status0", adr(0, 0), 32'd0);
      rd("rst_period0", adr(0, 2), 32'd49999);
      rd("rst_control0", adr(0, 1), 32'd0);
      rd("rst_snap0", adr(0, 3), 32'd0);
      rd("rst_reserved5", adr(0, 5), 32'd0);
      // ch1 continuous, period 9: timeouts 10 and 20 clocks after START
      wr(adr(1, 2), 32'd9);
      wr(adr(1, 1), 32'h7);
      idle(9);
      chk("ch1_pre_to1", 32'h0, 32'h0F);
      chk("ch1_to1_irq", 32'h0A, 32'h0F);
      rd("ch1_status_run_to", adr(1, 0), 32'd3);
      wr(adr(1, 0), 32'd0);
      chk("ch1_to_cleared", 32'h0, 32'h0F);
      idle(5);
      chk("ch1_pre_to2", 32'h0, 32'h0F);
      chk("ch1_to2_irq", 32'h0A, 32'h0F);
      idle(1);
      wr(adr(1, 3), 32'd0);
      rd("ch1_snap_run", adr(1, 3), 32'd7);
      wr(adr(1, 2), 32'hABCD_0005);
      rd("ch1_status_after_period", adr(1, 0), 32'd1);
      rd("ch1_period_trunc", adr(1, 2), 32'd5);
      wr(adr(1, 3), 32'd0);
      rd("ch1_snap_stopped", adr(1, 3), 32'd5);
      wr(adr(1, 1), 32'd0);
      wr(adr(1, 0), 32'd0);
      chk("ch1_quiet", 32'h0, 32'h0F);
      // ch0 one-shot, period 4, PRE 2: timeout 15 clocks after START
      wr(adr(0, 2), 32'd4);
      wr(adr(0, 1), 32'h205);
      idle(14);
      rd("ch0_os_before", adr(0, 0), 32'd2);
      rd("ch0_os_timeout", adr(0, 0), 32'd1);
      chk("ch0_os_irq", 32'h09, 32'h0F);
      wr(adr(0, 3), 32'd0);
      rd("ch0_os_cnt_hold", adr(0, 3), 32'd4);
      // ch0 continuous, period 3: STATUS write on the timeout edge keeps TO
      wr(adr(0, 0), 32'd0);
      wr(adr(0, 2), 32'd3);
      wr(adr(0, 1), 32'h7);
      idle(3);
      wr(adr(0, 0), 32'd0);
      chk("ch0_to_survives_clear", 32'h09, 32'h0F);
      wr(adr(0, 0), 32'd0);
      chk("ch0_to_cleared", 32'h0, 32'h0F);
      wr(adr(0, 1), 32'h8);
      wr(adr(0, 1), 32'hC);
      rd("ch0_start_beats_stop", adr(0, 0), 32'd3);
      wr(adr(0, 0), 32'd0);
      idle(1);
      wr(adr(0, 2), 32'd7);
      rd("ch0_period_vs_timeout", adr(0, 0), 32'd1);
      wr(adr(0, 3), 32'd0);
      rd("ch0_period_load_wins", adr(0, 3), 32'd7);
      // unmapped channel 3 and register details on ch2
      wr(adr(3, 2), 32'd123);
      rd("ch3_period_zero", adr(3, 2), 32'd0);
      rd("ch3_control_zero", adr(3, 1), 32'd0);
      rd("ch2_period_untouched", adr(2, 2), 32'd49999);
      wr(adr(2, 2), 32'h0001_0010);
      rd("ch2_period_width", adr(2, 2), 32'h10);
      wr(adr(2, 1), 32'h0000_FFFB);
      rd("ch2_control_bits", adr(2, 1), 32'hFF03);
      rd("ch2_status_idle", adr(2, 0), 32'd0);
      rd("ch2_reserved6", adr(2, 6), 32'd0);
      // ch1 PWM: period 9, compare 3, continuous
      wr(adr(1, 4), 32'd3);
      rd("ch1_compare", adr(1, 4), PWM_ON ? 32'd3 : 32'd0);
      wr(adr(1, 2), 32'd9);
      wr(adr(1, 1), 32'h6);
      for (int k = 0; k < 20; k++)
         chk($sformatf("pwm_k%0d", k), PWM_ON ? {26'd0, pwm_pat[k], 5'd0} : 32'd0, 32'h70);
      wr(adr(1, 2), 32'd9);
      // reset in the middle of a running count
      wr(adr(0, 1), 32'h7);
      idle(3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_outputs", 32'h0, 32'h7F);
      rd("midrst_status0", adr(0, 0), 32'd0);
      rd("midrst_period0", adr(0, 2), 32'd49999);
      rd("midrst_snap0", adr(0, 3), 32'd0);
      rd("midrst_control0", adr(0, 1), 32'd0);
      rd("midrst_compare1", adr(1, 4), 32'd0);
      idle(5);
      wr(adr(0, 3), 32'd0);
      rd("midrst_cnt_stopped", adr(0, 3), 32'd49999);
      idle(2);
      end_chk = 1'b1;
      step();
      end_chk = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
